// File: rtl/matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// matrix_result_streamer
//
// Purpose:
//   Captures one complete C matrix from the matrix multiplier on a single-cycle
//   valid_i pulse. It then replays that matrix one element per beat on a
//   valid/ready stream. Each beat carries the element's row/column tags, and
//   the final beat of the matrix is flagged with m_last_o.
//
//   The block holds a single matrix buffer. A new matrix is accepted only
//   while the buffer is idle. A valid_i pulse that arrives while a matrix is
//   still being streamed is dropped, and the sticky overflow_o flag is set.
//   overflow_o is cleared only by reset.
//
// Configuration:
//   MATRIX_STREAMER_COLUMN_MAJOR_EN
//     Defined:   elements are emitted in column-major order.
//     Undefined: elements are emitted in row-major order (default).
//   In both orders the tags give the element's true (row, col) position, and
//   m_last_o marks element (A_ROWS-1, B_COLUMNS-1).
//
// Ports:
//   clk_i       in   clock; all logic is on the rising edge
//   reset_i     in   synchronous active-high reset
//   valid_i     in   a matrix is present on c_i this cycle
//   c_i         in   N elements; element (r,c) is at index r*B_COLUMNS+c
//   ready_o     out  buffer idle; a valid_i this cycle is captured
//   overflow_o  out  sticky; a matrix was dropped
//   m_valid_o   out  stream beat valid
//   m_ready_i   in   sink accepts the beat
//   m_data_o    out  element value
//   m_row_o     out  row index of the beat
//   m_col_o     out  column index of the beat
//   m_last_o    out  final beat of the matrix
// -----------------------------------------------------------------------------
module matrix_result_streamer #(
  parameter  int C_DATA_WIDTH = 18,
  parameter  int A_ROWS       = 8,
  parameter  int B_COLUMNS    = 5,
  localparam int N            = A_ROWS * B_COLUMNS,
  localparam int RW           = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
  localparam int CW           = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [0:N-1],
  output logic                    ready_o,
  output logic                    overflow_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [C_DATA_WIDTH-1:0] m_data_o,
  output logic [RW-1:0]           m_row_o,
  output logic [CW-1:0]           m_col_o,
  output logic                    m_last_o
);

  localparam int          IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(A_ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(B_COLUMNS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic                    overflow_q, overflow_d;
  logic                    capture_en;
  logic [RW-1:0]           nxt_row;
  logic [CW-1:0]           nxt_col;

  // Matrix buffer. It is deliberately not reset, because its contents are
  // only read after a capture has written them.
  logic [C_DATA_WIDTH-1:0] mem_q [0:N-1];

  function automatic logic [IW-1:0] elem_idx(input logic [RW-1:0] r,
                                             input logic [CW-1:0] c);
    return IW'(r) * IW'(B_COLUMNS) + IW'(c);
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    data_d     = data_q;
    last_d     = last_q;
    capture_en = 1'b0;
    nxt_row    = row_q;
    nxt_col    = col_q;
    // Any matrix that arrives while the buffer is busy is lost.
    overflow_d = overflow_q | (valid_i & (state_q == STREAM));

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          capture_en = 1'b1;
          state_d    = STREAM;
          row_d      = '0;
          col_d      = '0;
          // The first beat is presented in the cycle right after capture.
          // Its data therefore comes straight from c_i, not from the buffer.
          data_d     = c_i[0];
          last_d     = (N == 1);
        end
      end

      STREAM: begin
        if (m_ready_i) begin
          if (last_q) begin
            // Return all output registers to their idle/reset values.
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
`ifdef MATRIX_STREAMER_COLUMN_MAJOR_EN
            if (row_q == ROW_MAX) begin
              nxt_row = '0;
              nxt_col = col_q + 1'b1;
            end else begin
              nxt_row = row_q + 1'b1;
            end
`else
            if (col_q == COL_MAX) begin
              nxt_col = '0;
              nxt_row = row_q + 1'b1;
            end else begin
              nxt_col = col_q + 1'b1;
            end
`endif
            row_d  = nxt_row;
            col_d  = nxt_col;
            // Look ahead one element so that the data output stays registered.
            data_d = mem_q[elem_idx(nxt_row, nxt_col)];
            last_d = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      data_q     <= data_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  // The buffer write is harmless during reset: the state stays IDLE, so the
  // written contents are never streamed.
  always_ff @(posedge clk_i) begin
    if (capture_en) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= c_i[k];
      end
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign m_valid_o  = (state_q == STREAM);
  assign overflow_o = overflow_q;
  assign m_data_o   = data_q;
  assign m_row_o    = row_q;
  assign m_col_o    = col_q;
  assign m_last_o   = last_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_streamer
//
// Directed bench for matrix_result_streamer with the default 8x5 geometry.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge before the inputs change. The expected beat order follows
// MATRIX_STREAMER_COLUMN_MAJOR_EN, so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_matrix_result_streamer;

  localparam int DW = 18;
  localparam int AR = 8;
  localparam int BC = 5;
  localparam int N  = AR * BC;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [DW-1:0] c_i [0:N-1];
  logic          ready_o;
  logic          overflow_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [2:0]    m_row_o;
  logic [2:0]    m_col_o;
  logic          m_last_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  matrix_result_streamer #(
    .C_DATA_WIDTH(DW),
    .A_ROWS      (AR),
    .B_COLUMNS   (BC)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .valid_i   (valid_i),
    .c_i       (c_i),
    .ready_o   (ready_o),
    .overflow_o(overflow_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_row_o   (m_row_o),
    .m_col_o   (m_col_o),
    .m_last_o  (m_last_o)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_matrix(input int base);
    for (int k = 0; k < N; k++) c_i[k] = DW'(base + k);
  endtask

  // Hold valid_i high across exactly one rising edge.
  task automatic pulse_valid();
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  // Map beat number k to the expected (row, col) of that beat.
  task automatic beat_pos(input int k, output int r, output int c);
`ifdef MATRIX_STREAMER_COLUMN_MAJOR_EN
    r = k % AR;
    c = k / AR;
`else
    r = k / BC;
    c = k % BC;
`endif
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    check_value({tag, "_valid"}, 32'(m_valid_o), 0);
    check_value({tag, "_ready"}, 32'(ready_o), 1);
    check_value({tag, "_ovf"},   32'(overflow_o), 32'(exp_ovf));
    check_value({tag, "_last"},  32'(m_last_o), 0);
    check_value({tag, "_data"},  32'(m_data_o), 0);
    check_value({tag, "_row"},   32'(m_row_o), 0);
    check_value({tag, "_col"},   32'(m_col_o), 0);
  endtask

  // Drain one matrix. Call this at the falling edge that follows the capture
  // edge.
  //   bp   : 1 applies the m_ready_i pattern 1,0,0,1; 0 holds m_ready_i high.
  //   kind : 0 plain drain
  //          1 inject a second matrix (base 500) at beat inj
  //          2 assert reset at beat inj
  task automatic drain(input string tag, input int base, input bit bp,
                       input int kind, input int inj, input logic ovf0);
    int  beat;
    int  cyc;
    int  r;
    int  c;
    bit  ovf_exp;
    bit  injected;
    beat     = 0;
    cyc      = 0;
    ovf_exp  = ovf0;
    injected = 1'b0;
    while (beat < N && cyc < 400) begin
      beat_pos(beat, r, c);
      m_ready_i = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      check_value({tag, "_mvalid"}, 32'(m_valid_o), 1);
      check_value({tag, "_ready_lo"}, 32'(ready_o), 0);
      check_value({tag, "_data"}, 32'(m_data_o), 32'(base + r * BC + c));
      check_value({tag, "_row"}, 32'(m_row_o), 32'(r));
      check_value({tag, "_col"}, 32'(m_col_o), 32'(c));
      check_value({tag, "_last"}, 32'(m_last_o), 32'(beat == N - 1));
      check_value({tag, "_ovf"}, 32'(overflow_o), 32'(ovf_exp));
      if (kind == 2 && beat == inj) begin
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        check_idle({tag, "_rst"}, 1'b0);
        return;
      end
      if (kind == 1 && beat == inj && !injected) begin
        load_matrix(500);
        valid_i  = 1'b1;
        injected = 1'b1;
      end
      if (m_ready_i) beat++;
      cyc++;
      @(negedge clk_i);
      if (valid_i) begin
        valid_i = 1'b0;
        ovf_exp = 1'b1;
      end
    end
    check_value({tag, "_beats"}, 32'(beat), 32'(N));
    // ready_o must rise in the cycle after the last-beat handshake.
    check_value({tag, "_end_valid"}, 32'(m_valid_o), 0);
    check_value({tag, "_end_ready"}, 32'(ready_o), 1);
    check_value({tag, "_end_ovf"}, 32'(overflow_o), 32'(ovf_exp));
  endtask

  initial begin
    reset_i   = 1'b1;
    valid_i   = 1'b1;
    m_ready_i = 1'b1;
    load_matrix(900);
    // Reset together with valid_i: reset wins and nothing is captured.
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    valid_i = 1'b0;
    check_idle("reset", 1'b0);
    @(negedge clk_i);
    check_idle("reset_hold", 1'b0);

    // Row-major drain (or column-major, depending on the build).
    load_matrix(100);
    pulse_valid();
    drain("drain", 100, 1'b0, 0, 0, 1'b0);

    // Backpressure.
    load_matrix(300);
    pulse_valid();
    drain("bp", 300, 1'b1, 0, 0, 1'b0);

    // Overflow: a second matrix arrives at beat 10 and must be dropped.
    load_matrix(100);
    pulse_valid();
    drain("ovf", 100, 1'b0, 1, 10, 1'b0);
    @(negedge clk_i);
    check_value("ovf_sticky", 32'(overflow_o), 1);
    check_value("ovf_no_capture", 32'(m_valid_o), 0);

    // Reset mid-stream at beat 20, then a fresh capture.
    load_matrix(100);
    pulse_valid();
    drain("rst_mid", 100, 1'b0, 2, 20, 1'b1);
    load_matrix(200);
    pulse_valid();
    drain("after_rst", 200, 1'b0, 0, 0, 1'b0);

    // Back-to-back: valid_i pulses spaced N+1 = 41 cycles apart.
    for (int m = 0; m < 3; m++) begin
      load_matrix(600 + 100 * m);
      pulse_valid();
      drain($sformatf("b2b%0d", m), 600 + 100 * m, 1'b0, 0, 0, 1'b0);
    end
    check_value("b2b_ovf", 32'(overflow_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

- Drains the flat result array of the matrix multiplier: captures a full C matrix on a one-cycle `valid_i` pulse.
- Replays the captured matrix one element per beat on a valid/ready stream, with row/column tags and a last-beat marker.
- Sits directly after the multiplier's registered `c_o`/`valid_o` outputs; the stream side feeds narrow downstream sinks (packers, DMA, checkers).
- Holds one matrix buffer only; a new matrix is accepted only when the buffer is idle.

## Interface

Parameters:
- `C_DATA_WIDTH`, 18: width of each result element.
- `A_ROWS`, 8: rows of C.
- `B_COLUMNS`, 5: columns of C.
- Derived: N = `A_ROWS*B_COLUMNS`; RW = max(1,$clog2(`A_ROWS`)); CW = max(1,$clog2(`B_COLUMNS`)).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  matrix present on `c_i` this cycle.
- `c_i`  in  `C_DATA_WIDTH` x [0:N-1]  result matrix, element (r,c) at index r*`B_COLUMNS`+c.
- `ready_o`  out  1  buffer idle; a `valid_i` this cycle is captured.
- `overflow_o`  out  1  sticky: a matrix was dropped.
- `m_valid_o`  out  1  stream beat valid.
- `m_ready_i`  in  1  sink accepts beat.
- `m_data_o`  out  `C_DATA_WIDTH`  element value.
- `m_row_o`  out  RW  row index of the beat.
- `m_col_o`  out  CW  column index of the beat.
- `m_last_o`  out  1  final beat of the matrix.

## Operation

- FSM has two states, IDLE and STREAM. Reset enters IDLE.
- IDLE:
  - `ready_o`=1, `m_valid_o`=0.
  - `valid_i`=1 copies all N elements of `c_i` into the buffer, clears the row/column counters, and enters STREAM.
- STREAM:
  - `ready_o`=0, `m_valid_o`=1.
  - `m_data_o` = buffer[`m_row_o`*`B_COLUMNS`+`m_col_o`].
  - A beat completes on `m_valid_o & m_ready_i`. The counters then advance in emission order.
  - On the last beat (row=`A_ROWS`-1, col=`B_COLUMNS`-1 in row-major order), completion returns the FSM to IDLE.
- Emission order, row-major (default): the column counter increments. At `B_COLUMNS`-1 it wraps to 0 and the row counter increments.
- `m_last_o` = 1 only on the final beat of the current emission order.
- Overflow: `valid_i`=1 while `ready_o`=0 discards the input, leaves the buffer unchanged, and sets `overflow_o`. `overflow_o` clears only on reset.
- Data width: elements pass through unmodified; no arithmetic.

## Timing

- Reset values: `ready_o`=1, `overflow_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `m_row_o`=0, `m_col_o`=0.
- The buffer contents are not reset.
- Capture at edge T gives the first beat valid in cycle T+1.
- With `m_ready_i` held at 1, a matrix takes exactly N STREAM cycles plus 1 IDLE cycle.
- Throughput: one matrix per N+1 cycles. A multiplier `valid_o` pulse arriving faster than this sets the overflow flag.
- All outputs are registered. The valid/ready rules are:
  - While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o`, `m_row_o`, `m_col_o` and `m_last_o` hold stable.
  - `m_valid_o` never drops without a handshake.
- `m_ready_i` may be high while `m_valid_o`=0; it has no effect.
- `ready_o` rises in the cycle after the last-beat handshake. It is never combinationally dependent on `m_ready_i`.
- Reset during STREAM aborts the matrix immediately. The next cycle is IDLE with all outputs at reset values.
- Simultaneous `reset_i` and `valid_i`: reset wins and nothing is captured.
- N=1 (1x1): the single beat has `m_last_o`=1, `m_row_o`=0 and `m_col_o`=0.

## Configuration

- `MATRIX_STREAMER_COLUMN_MAJOR_EN` defined: column-major emission.
  - The row counter increments and wraps at `A_ROWS`-1, then the column counter increments.
  - `m_last_o` marks row=`A_ROWS`-1, col=`B_COLUMNS`-1.
  - Tags still give the true (r,c) position.
- Undefined: row-major emission as in Operation.
- Latency, handshake and overflow behaviour are identical in both builds.

## Test plan

- **Row-major drain:** defaults, c_i[k]=k+100, `valid_i` pulse, `m_ready_i`=1.
  - 40 beats in consecutive cycles starting one cycle after capture.
  - Beat k carries data k+100, row k/5, col k%5.
  - `m_last_o` only on beat 39 (data 139, row 7, col 4).
  - `ready_o` returns to 1 one cycle later.
- **Backpressure:** toggle `m_ready_i` 1,0,0,1 repeatedly.
  - Data and tags hold stable during stalls.
  - Exactly 40 unique beats, none duplicated or skipped.
  - `m_valid_o` never drops mid-matrix.
- **Overflow:** second `valid_i` pulse with c_i[k]=k+500 at beat 10 of a stream.
  - Stream continues with values 110..139.
  - `overflow_o`=1 from the following cycle until reset.
  - No 5xx values are ever emitted.
- **Reset mid-stream:** assert `reset_i` at beat 20.
  - Next cycle: `m_valid_o`=0, `ready_o`=1, `overflow_o`=0.
  - A fresh capture of c_i[k]=k+200 then streams 200..239 from beat 0.
- **Column-major build:** same stimulus as the row-major drain, with `MATRIX_STREAMER_COLUMN_MAJOR_EN`.
  - Beat order is data 100,105,110,...,135,101,....
  - Beat 1 has row 1, col 0.
  - The last beat is data 139, row 7, col 4.
- **Back-to-back with multiplier:** 3 `valid_i` pulses spaced 41 cycles apart.
  - All 120 beats delivered in order.
  - `overflow_o` stays 0.
